updown_mod_counter: RTL and testbench
=====================================

Name: updown_mod_counter

Overview:
Parametrised general-purpose counter that generalises the team's fixed 8-bit free-running up counter. It adds configurable width, arbitrary modulus, up/down direction, synchronous parallel load, wrap or saturate mode, an enable prescaler, and boundary status flags. It is intended as the standard counting primitive for timers, address generators and event counters across the design. The default parameters give the same count range and the same enabled-every-cycle behaviour as the 8-bit up counter.

Parameters:
WIDTH, 8, counter width in bits; legal range 1..32.
MODULUS, 256, count range is 0..MODULUS-1; legal range 2..2**WIDTH.
PRESCALE, 1, number of enabled cycles per count step; must be at least 1.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
enable  in  1  count enable; a high level advances the prescaler.
up  in  1  direction; 1 counts up, 0 counts down; sampled on each step.
saturate  in  1  boundary mode; 1 holds at the boundary, 0 wraps.
load  in  1  synchronous parallel load.
load_value  in  WIDTH  value to load.
out  out  WIDTH  registered count value.
wrap  out  1  registered one-cycle pulse in the cycle out shows a wrapped value.
at_max  out  1  high when out == MODULUS-1; decoded from the registered out.
at_min  out  1  high when out == 0; decoded from the registered out.

Behaviour:
- Reset:
  - one clock; reset is synchronous and active-high.
  - In the cycle after reset is sampled high: out=0, wrap=0, prescale count=0, at_min=1, at_max=0.
  - Reset overrides every other input, including mid-prescale and mid-load.
- Priority: reset > load > step > hold.
- Load:
  - out <= load_value; values of MODULUS or above are clamped to MODULUS-1.
  - The prescale count is cleared to 0 and wrap is 0.
  - Load applies regardless of enable.
- Prescaler:
  - An internal counter ps (width $clog2(PRESCALE), minimum 1) increments on each enabled cycle.
  - A step occurs when enable=1 and ps==PRESCALE-1; ps then returns to 0.
  - When enable=0, ps holds its value.
  - With PRESCALE=1, a step occurs on every enabled cycle.
- Step, counting up:
  - If out < MODULUS-1: out <= out+1.
  - If out == MODULUS-1 and saturate=0: out <= 0 and wrap=1.
  - If out == MODULUS-1 and saturate=1: out holds and wrap=0.
- Step, counting down:
  - If out > 0: out <= out-1.
  - If out == 0 and saturate=0: out <= MODULUS-1 and wrap=1.
  - If out == 0 and saturate=1: out holds and wrap=0.
- wrap timing:
  - wrap is high exactly in the cycle following the wrapping edge, alongside the new out value.
  - It is 0 in all other cycles, including hold, load and reset cycles.
- Latency: one clock from the sampling edge to out. at_max and at_min follow out with no added latency.
- Arithmetic:
  - Boundary compares are done before the add or subtract, so out never leaves the range 0..MODULUS-1.
  - The MODULUS-1 constant is computed in WIDTH+1 bits so that MODULUS=2**WIDTH is legal.
- Direction or mode changes between steps take effect at the next step. They do not disturb ps.
- No combinational path runs from any input to any output.

Test Plan:
- WIDTH=4, MODULUS=10, PRESCALE=1, up=1, saturate=0, enable held high from out=0 -> out steps 0..9, then 0 with wrap=1 for exactly one cycle; at_max=1 while out=9.
- Same configuration, up=0, starting from out=0 -> out goes 9,8,..., with wrap=1 in the cycle out becomes 9; at_min=1 while out=0.
- saturate=1, up=1, load 9, enable held high for 5 cycles -> out stays 9, wrap stays 0, at_max stays 1. Then switch up=0 -> out=8 after the next step.
- PRESCALE=3, enable high for 2 cycles, low for 4 cycles, then high for 1 cycle -> out goes from 0 to 1 only on the third enabled cycle. A load of 5 mid-prescale -> out=5 and the next step comes 3 enabled cycles later.
- load_value=12 with MODULUS=10 -> out=9. load and enable asserted together -> load wins. Reset asserted together with load -> out=0, wrap=0.
- Defaults (WIDTH=8, MODULUS=256), enable high from out=0 for 256 cycles -> out reaches 255, then 0 with wrap=1; no X on any output after the first reset.

Source files
------------

// File: rtl/updown_mod_counter.sv
// updown_mod_counter: parametrised modulo counter with up/down, load, wrap/saturate, prescaler and boundary flags
// Ports: clk, reset (sync, active-high), enable (advances prescaler), up (direction),
//   saturate (1 holds at boundary, 0 wraps), load/load_value (parallel load, clamped to MODULUS-1),
//   out (registered count), wrap (one-cycle pulse with the wrapped value), at_max/at_min (decoded from out)
module updown_mod_counter #(
  parameter int              WIDTH    = 8,
  parameter longint unsigned MODULUS  = 256,
  parameter int              PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic             saturate,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] out,
  output logic             wrap,
  output logic             at_max,
  output logic             at_min
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  // held in WIDTH+1 bits so MODULUS == 2**WIDTH stays representable
  localparam logic [WIDTH:0]   MAX_W   = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX     = MAX_W[WIDTH-1:0];
  localparam logic [PW-1:0]    PS_LAST = PW'(PRESCALE - 1);
  logic [PW-1:0]    ps;
  logic             step, bound;
  logic [WIDTH-1:0] nxt, clamped;
  assign step    = enable && ps == PS_LAST;
  assign bound   = up ? out == MAX : out == '0;
  assign clamped = {1'b0, load_value} > MAX_W ? MAX : load_value;
  // boundary tested before add/subtract so out never leaves 0..MODULUS-1
  assign nxt     = bound ? (saturate ? out : (up ? '0 : MAX)) : (up ? out + 1'b1 : out - 1'b1);
  always_ff @(posedge clk) begin
    if (reset) begin
      out  <= '0;
      wrap <= 1'b0;
      ps   <= '0;
    end else if (load) begin
      out  <= clamped;
      wrap <= 1'b0;
      ps   <= '0;
    end else begin
      wrap <= step && bound && !saturate;
      if (enable) ps <= step ? '0 : ps + 1'b1;
      if (step) out <= nxt;
    end
  end
  assign at_max = out == MAX;
  assign at_min = out == '0;
endmodule

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter: three counter configurations checked against an arithmetic model every cycle
module tb_updown_mod_counter;
  logic       clk = 0, reset = 0, enable = 0, up = 1, saturate = 0, load = 0;
  logic [7:0] lv = 0;
  logic [3:0] a_out, b_out;
  logic [7:0] c_out;
  logic       a_wrap, a_max, a_min, b_wrap, b_max, b_min, c_wrap, c_max, c_min;
  int total = 0, bad = 0;
  bit valid = 0;
  int mods[3]  = '{10, 10, 256};
  int pres[3]  = '{1, 3, 1};
  int masks[3] = '{15, 15, 255};
  int mc[3], mp[3], mw[3];

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) ua (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .saturate(saturate), .load(load),
    .load_value(lv[3:0]), .out(a_out), .wrap(a_wrap), .at_max(a_max), .at_min(a_min));
  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) ub (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .saturate(saturate), .load(load),
    .load_value(lv[3:0]), .out(b_out), .wrap(b_wrap), .at_max(b_max), .at_min(b_min));
  updown_mod_counter uc (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .saturate(saturate), .load(load),
    .load_value(lv), .out(c_out), .wrap(c_wrap), .at_max(c_max), .at_min(c_min));

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset) valid = 1;
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        mc[i] = 0; mp[i] = 0; mw[i] = 0;
      end else if (load) begin
        mc[i] = (int'(lv) & masks[i]) >= mods[i] ? mods[i] - 1 : int'(lv) & masks[i];
        mp[i] = 0; mw[i] = 0;
      end else begin
        mw[i] = 0;
        if (enable) begin
          if (mp[i] == pres[i] - 1) begin
            mp[i] = 0;
            if (up) begin
              if (mc[i] < mods[i] - 1) mc[i]++;
              else if (!saturate) begin mc[i] = 0; mw[i] = 1; end
            end else begin
              if (mc[i] > 0) mc[i]--;
              else if (!saturate) begin mc[i] = mods[i] - 1; mw[i] = 1; end
            end
          end else mp[i]++;
        end
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (valid) begin
      chk("a_out", {28'b0, a_out}, mc[0]); chk("a_wrap", {31'b0, a_wrap}, mw[0]);
      chk("a_max", {31'b0, a_max}, mc[0] == 9 ? 1 : 0); chk("a_min", {31'b0, a_min}, mc[0] == 0 ? 1 : 0);
      chk("b_out", {28'b0, b_out}, mc[1]); chk("b_wrap", {31'b0, b_wrap}, mw[1]);
      chk("b_max", {31'b0, b_max}, mc[1] == 9 ? 1 : 0); chk("b_min", {31'b0, b_min}, mc[1] == 0 ? 1 : 0);
      chk("c_out", {24'b0, c_out}, mc[2]); chk("c_wrap", {31'b0, c_wrap}, mw[2]);
      chk("c_max", {31'b0, c_max}, mc[2] == 255 ? 1 : 0); chk("c_min", {31'b0, c_min}, mc[2] == 0 ? 1 : 0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  initial begin
    #1;
    reset = 1; cyc(1);
    chk("lit_rst_out", {28'b0, a_out}, 0); chk("lit_rst_min", {31'b0, a_min}, 1);
    chk("lit_rst_wrap", {31'b0, a_wrap}, 0); chk("lit_rst_max", {31'b0, a_max}, 0);
    reset = 0; enable = 1; up = 1; saturate = 0;
    cyc(9);
    chk("lit_up9", {28'b0, a_out}, 9); chk("lit_up9_max", {31'b0, a_max}, 1);
    cyc(1);
    chk("lit_upwrap_out", {28'b0, a_out}, 0); chk("lit_upwrap", {31'b0, a_wrap}, 1);
    cyc(1);
    chk("lit_up1", {28'b0, a_out}, 1); chk("lit_wrap_drop", {31'b0, a_wrap}, 0);
    reset = 1; cyc(1);
    chk("lit_rst_en", {28'b0, a_out}, 0);
    reset = 0; up = 0; cyc(1);
    chk("lit_dn_out", {28'b0, a_out}, 9); chk("lit_dn_wrap", {31'b0, a_wrap}, 1);
    cyc(1);
    chk("lit_dn8", {28'b0, a_out}, 8);
    saturate = 1; up = 1; load = 1; lv = 9; cyc(1);
    chk("lit_ld9", {28'b0, a_out}, 9);
    load = 0; cyc(5);
    chk("lit_sat_out", {28'b0, a_out}, 9); chk("lit_sat_wrap", {31'b0, a_wrap}, 0);
    chk("lit_sat_max", {31'b0, a_max}, 1);
    up = 0; cyc(1);
    chk("lit_sat_dn", {28'b0, a_out}, 8);
    up = 1; saturate = 0; enable = 0; reset = 1; cyc(1);
    reset = 0; enable = 1; cyc(2);
    enable = 0; cyc(4);
    chk("lit_ps_hold", {28'b0, b_out}, 0);
    enable = 1; cyc(1);
    chk("lit_ps_step", {28'b0, b_out}, 1);
    cyc(1);
    load = 1; lv = 5; cyc(1);
    chk("lit_ps_ld", {28'b0, b_out}, 5);
    load = 0; cyc(2);
    chk("lit_ps_wait", {28'b0, b_out}, 5);
    cyc(1);
    chk("lit_ps_next", {28'b0, b_out}, 6);
    load = 1; lv = 12; cyc(1);
    chk("lit_clamp", {28'b0, a_out}, 9); chk("lit_ld_c", {24'b0, c_out}, 12);
    lv = 3; cyc(1);
    chk("lit_ld_wins", {28'b0, a_out}, 3);
    reset = 1; cyc(1);
    chk("lit_rst_ld", {28'b0, a_out}, 0); chk("lit_rst_ld_w", {31'b0, a_wrap}, 0);
    reset = 0; load = 0; up = 1; saturate = 0; enable = 1; cyc(255);
    chk("lit_c255", {24'b0, c_out}, 255); chk("lit_c_max", {31'b0, c_max}, 1);
    cyc(1);
    chk("lit_c_wrap_out", {24'b0, c_out}, 0); chk("lit_c_wrap", {31'b0, c_wrap}, 1);
    enable = 0; cyc(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
